// File: rtl/arithmetic_unit_seq.sv
// Multi-cycle add/subtract unit: WIDTH-bit operation processed SLICE bits per clock,
// with registered inter-slice carry, persistent carry flag and valid/ready handshakes.
module arithmetic_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             carry_flag
);
    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_cflag;
    logic [CW-1:0]    r_cnt;

    logic [31:0]      w_base;
    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_full;
    logic             w_cin;
    logic             w_last;

    assign w_base = 32'(r_cnt) * SLICE;
    assign w_last = (r_cnt == LAST);
    // ADC/SBB chain through the persistent flag; plain SUB injects the two's complement +1.
    assign w_cin  = op[1] ? r_cflag : op[0];

    assign {w_slice_cout, w_slice_sum} = {1'b0, r_a[w_base +: SLICE]}
                                       + {1'b0, r_b[w_base +: SLICE]}
                                       + {{SLICE{1'b0}}, r_carry};

    always_comb begin
        w_sum_full = r_sum;
        w_sum_full[w_base +: SLICE] = w_slice_sum;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (in_valid) w_state_next = StRun;
            StRun:  if (w_last) w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_cflag <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{op[0]}};
                        r_carry <= w_cin;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    r_sum   <= w_sum_full;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_z     <= w_sum_full;
                        r_cout  <= w_slice_cout;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                                && (w_sum_full[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero  <= (w_sum_full == '0);
                        r_cflag <= w_slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == StIdle);
    assign out_valid  = (r_state == StDone);
    assign z          = r_z;
    assign cout       = r_cout;
    assign overflow   = r_ovf;
    assign zero       = r_zero;
    assign carry_flag = r_cflag;

endmodule
